// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared encodings for the keypad scanner and encoder stages.
//  Revision    : 1.0
// ============================================================================
package keypad_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t BARRIDO    = 2'd0;
    localparam estado_t REBOTE_P   = 2'd1;
    localparam estado_t PRESIONADA = 2'd2;
    localparam estado_t REBOTE_L   = 2'd3;

    localparam logic [3:0] TECLA_DEFECTO = 4'b0011;
    localparam logic [3:0] COL_IDLE      = 4'b1111;

    // Lowest-index active-low row wins when several keys share a column.
    function automatic logic [1:0] fila_mas_baja(input logic [3:0] filas_s);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!filas_s[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] col_drive_n(input logic [1:0] col);
        return COL_IDLE & ~(4'b0001 << col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sincronizador_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_2ff
//  Description : Two-flop synchronizer, resets to all ones (idle pull-ups).
//  Revision    : 1.0
// ============================================================================
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/escaner_teclado.sv
`default_nettype none
// ============================================================================
//  Module      : escaner_teclado
//  Description : 4x4 keypad column scanner with press/release debounce.
//  Revision    : 1.0
// ============================================================================
module escaner_teclado
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas_n_in,
    output logic [3:0] columnas_n_out,
    output logic [1:0] filas_out,
    output logic [1:0] columnas_out,
    output logic       hold,
    output logic       tecla_pulso
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] c_dwell_fin = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] c_deb_fin   = BW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    w_filas_s;
    logic          w_alguna;
    logic          w_fila_libre;

    estado_t       r_estado;
    logic [1:0]    r_col;
    logic [1:0]    r_fila;
    logic [DW-1:0] r_dwell;
    logic [BW-1:0] r_deb;
    logic [3:0]    r_columnas_n;
    logic [1:0]    r_filas_out;
    logic [1:0]    r_columnas_out;
    logic          r_hold;
    logic          r_pulso;

    sincronizador_2ff #(
        .WIDTH (4)
    ) u_sync_filas (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (filas_n_in),
        .q     (w_filas_s)
    );

    assign w_alguna     = ~&w_filas_s;
    assign w_fila_libre = w_filas_s[r_fila];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado       <= BARRIDO;
            r_col          <= 2'd0;
            r_fila         <= 2'd0;
            r_dwell        <= '0;
            r_deb          <= '0;
            r_columnas_n   <= 4'b1110;
            r_filas_out    <= 2'd0;
            r_columnas_out <= 2'd0;
            r_hold         <= 1'b0;
            r_pulso        <= 1'b0;
        end else begin
            r_pulso <= 1'b0;
            case (r_estado)
                BARRIDO: begin
                    if (r_dwell == c_dwell_fin) begin
                        r_dwell <= '0;
                        if (w_alguna) begin
                            // Column stays driven while the candidate key is debounced.
                            r_fila   <= fila_mas_baja(w_filas_s);
                            r_deb    <= '0;
                            r_estado <= REBOTE_P;
                        end else begin
                            r_col        <= r_col + 2'd1;
                            r_columnas_n <= col_drive_n(r_col + 2'd1);
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                REBOTE_P: begin
                    if (w_fila_libre) begin
                        r_deb        <= '0;
                        r_dwell      <= '0;
                        r_col        <= r_col + 2'd1;
                        r_columnas_n <= col_drive_n(r_col + 2'd1);
                        r_estado     <= BARRIDO;
                    end else if (r_deb == c_deb_fin) begin
                        r_deb          <= '0;
                        r_filas_out    <= r_fila;
                        r_columnas_out <= r_col;
                        r_hold         <= 1'b1;
                        r_pulso        <= 1'b1;
                        r_estado       <= PRESIONADA;
                    end else begin
                        r_deb <= r_deb + BW'(1);
                    end
                end
                PRESIONADA: begin
                    if (w_fila_libre) begin
                        r_deb    <= '0;
                        r_estado <= REBOTE_L;
                    end
                end
                REBOTE_L: begin
                    if (!w_fila_libre) begin
                        r_deb    <= '0;
                        r_estado <= PRESIONADA;
                    end else if (r_deb == c_deb_fin) begin
                        r_deb        <= '0;
                        r_dwell      <= '0;
                        r_hold       <= 1'b0;
                        r_col        <= r_col + 2'd1;
                        r_columnas_n <= col_drive_n(r_col + 2'd1);
                        r_estado     <= BARRIDO;
                    end else begin
                        r_deb <= r_deb + BW'(1);
                    end
                end
                default: r_estado <= BARRIDO;
            endcase
        end
    end

    assign columnas_n_out = r_columnas_n;
    assign filas_out      = r_filas_out;
    assign columnas_out   = r_columnas_out;
    assign hold           = r_hold;
    assign tecla_pulso    = r_pulso;

endmodule
`default_nettype wire

// File: tb/tb_escaner_teclado.sv
`default_nettype none
// ============================================================================
//  Module      : tb_escaner_teclado
//  Description : Directed bench for escaner_teclado (SCAN_DIV=4, DEBOUNCE=8).
//  Revision    : 1.0
// ============================================================================
module tb_escaner_teclado;

    logic        clk;
    logic        rst_n;
    logic [3:0]  filas_n_in;
    logic [3:0]  columnas_n_out;
    logic [1:0]  filas_out;
    logic [1:0]  columnas_out;
    logic        hold;
    logic        tecla_pulso;

    // keys[r*4+c] = 1 means the key at row r, column c is closed
    logic [15:0] keys;

    int n_cmp;
    int n_err;

    escaner_teclado #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .filas_n_in     (filas_n_in),
        .columnas_n_out (columnas_n_out),
        .filas_out      (filas_out),
        .columnas_out   (columnas_out),
        .hold           (hold),
        .tecla_pulso    (tecla_pulso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a closed key pulls its row low when its column is driven low.
    always_comb begin
        filas_n_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (|(keys[r*4 +: 4] & ~columnas_n_out)) filas_n_in[r] = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns after a rising edge with rst_n just released;
    // the next rising edge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        keys  = '0;
        rst_n = 1'b0;
        tick(2);
        n_cmp++;
        if (columnas_n_out !== 4'b1110 || hold !== 1'b0 || tecla_pulso !== 1'b0 ||
            filas_out !== 2'd0 || columnas_out !== 2'd0) begin
            n_err++;
            $display("FAIL reset_values: col=%b hold=%b pulso=%b filas=%0d cols=%0d, want 1110 0 0 0 0",
                     columnas_n_out, hold, tecla_pulso, filas_out, columnas_out);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_col = 4'b1111 & ~(4'b0001 << ((k / 4) % 4));
            n_cmp++;
            if (columnas_n_out !== exp_col) begin
                n_err++;
                $display("FAIL scan_edge%0d: col=%b want %b", k, columnas_n_out, exp_col);
            end
        end
    endtask

    task automatic test_clean_press();
        int extra;
        keys = '0;
        keys[2*4+1] = 1'b1;
        do_reset();
        // column 1 sampled at edge 8, hold at edge 16
        tick(15);
        n_cmp++;
        if (hold !== 1'b0 || tecla_pulso !== 1'b0 || columnas_n_out !== 4'b1101) begin
            n_err++;
            $display("FAIL press_before: hold=%b pulso=%b col=%b want 0 0 1101", hold, tecla_pulso, columnas_n_out);
        end
        tick(1);
        n_cmp++;
        if (hold !== 1'b1 || tecla_pulso !== 1'b1 || filas_out !== 2'd2 || columnas_out !== 2'd1) begin
            n_err++;
            $display("FAIL press_edge: hold=%b pulso=%b filas=%0d cols=%0d want 1 1 2 1",
                     hold, tecla_pulso, filas_out, columnas_out);
        end
        extra = 0;
        for (int i = 0; i < 34; i++) begin
            tick(1);
            if (tecla_pulso !== 1'b0 || hold !== 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL press_hold_steady: bad cycles=%0d want 0", extra);
        end
        // Pin rises before edge E0; FSM sees it at E2, hold falls at E10.
        keys = '0;
        tick(10);
        n_cmp++;
        if (hold !== 1'b1) begin
            n_err++;
            $display("FAIL release_early: hold=%b want 1", hold);
        end
        tick(1);
        n_cmp++;
        if (hold !== 1'b0 || columnas_n_out !== 4'b1011 || filas_out !== 2'd2 || columnas_out !== 2'd1) begin
            n_err++;
            $display("FAIL release_edge: hold=%b col=%b filas=%0d cols=%0d want 0 1011 2 1",
                     hold, columnas_n_out, filas_out, columnas_out);
        end
    endtask

    task automatic test_bounce();
        int bad;
        keys = '0;
        keys[1*4+2] = 1'b1;
        do_reset();
        tick(12);
        n_cmp++;
        if (columnas_n_out !== 4'b1011 || hold !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_sample: col=%b hold=%b want 1011 0", columnas_n_out, hold);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            keys[1*4+2] = ((i / 3) % 2) == 1;
            tick(1);
            if (hold !== 1'b0 || tecla_pulso !== 1'b0) bad++;
            if (i == 2) begin
                n_cmp++;
                if (columnas_n_out !== 4'b0111) begin
                    n_err++;
                    $display("FAIL bounce_next_col: col=%b want 0111", columnas_n_out);
                end
            end
        end
        keys = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (hold !== 1'b0 || tecla_pulso !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bounce_no_key: bad cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_release_glitch();
        int bad;
        keys = '0;
        keys[2*4+1] = 1'b1;
        do_reset();
        tick(16);
        n_cmp++;
        if (hold !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_pressed: hold=%b want 1", hold);
        end
        tick(5);
        bad = 0;
        keys = '0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (hold !== 1'b1 || tecla_pulso !== 1'b0) bad++;
        end
        keys[2*4+1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (hold !== 1'b1 || tecla_pulso !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL glitch_hold: bad cycles=%0d want 0", bad);
        end
        keys = '0;
        tick(12);
    endtask

    task automatic test_two_keys();
        keys = '0;
        keys[1*4+0] = 1'b1;
        keys[3*4+0] = 1'b1;
        do_reset();
        tick(11);
        n_cmp++;
        if (hold !== 1'b0) begin
            n_err++;
            $display("FAIL two_keys_early: hold=%b want 0", hold);
        end
        tick(1);
        n_cmp++;
        if (hold !== 1'b1 || tecla_pulso !== 1'b1 || filas_out !== 2'd1 || columnas_out !== 2'd0) begin
            n_err++;
            $display("FAIL two_keys: hold=%b pulso=%b filas=%0d cols=%0d want 1 1 1 0",
                     hold, tecla_pulso, filas_out, columnas_out);
        end
        keys = '0;
        tick(12);
    endtask

    task automatic test_reset_in_hold();
        int bad;
        keys = '0;
        keys[2*4+1] = 1'b1;
        do_reset();
        tick(20);
        n_cmp++;
        if (hold !== 1'b1) begin
            n_err++;
            $display("FAIL rst_hold_pre: hold=%b want 1", hold);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (hold !== 1'b0 || columnas_n_out !== 4'b1110 || tecla_pulso !== 1'b0 ||
            filas_out !== 2'd0 || columnas_out !== 2'd0) begin
            n_err++;
            $display("FAIL rst_hold_async: hold=%b col=%b pulso=%b filas=%0d cols=%0d want 0 1110 0 0 0",
                     hold, columnas_n_out, tecla_pulso, filas_out, columnas_out);
        end
        tick(1);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (hold !== 1'b0 || tecla_pulso !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rst_no_early_pulse: bad cycles=%0d want 0", bad);
        end
        tick(1);
        n_cmp++;
        if (hold !== 1'b1 || tecla_pulso !== 1'b1) begin
            n_err++;
            $display("FAIL rst_repress: hold=%b pulso=%b want 1 1", hold, tecla_pulso);
        end
        keys = '0;
        tick(12);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        keys  = '0;
        rst_n = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_two_keys();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
